// File: rtl/flappy_pkg.sv
// Shared game constants and types for the obstacle, collision/score and HUD blocks.
package flappy_pkg;

   localparam int T_W         = 29;
   localparam int S_Z         = 120;
   localparam int SCREEN_H    = 480;
   localparam int OBS_RESET_X = 670;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit ripple-carry BCD counter: adds 0..2 per cycle, synchronous clear, saturates at 9999.
module bcd_counter4
   import flappy_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic [1:0]  inc,
   output logic [15:0] o_value
);

   logic [15:0] r_val;
   logic [15:0] w_next;
   logic [4:0]  w_sum0;
   logic [4:1]  w_c;
   bcd_digit_t  w_dig;

   always_comb begin
      w_next = r_val;
      w_c    = '0;
      w_dig  = '0;
      w_sum0 = {1'b0, r_val[3:0]} + {3'b000, inc};
      if (w_sum0 > 5'd9) begin
         w_next[3:0] = w_sum0[3:0] - 4'd10;
         w_c[1]      = 1'b1;
      end else begin
         w_next[3:0] = w_sum0[3:0];
      end
      for (int k = 1; k < 4; k++) begin
         w_dig = r_val[4*k +: 4];
         if (w_c[k]) begin
            if (w_dig == 4'd9) begin
               w_next[4*k +: 4] = 4'd0;
               w_c[k+1]         = 1'b1;
            end else begin
               w_next[4*k +: 4] = w_dig + 4'd1;
            end
         end
      end
      // A carry out of the top digit means the true sum passed 9999.
      if (w_c[4]) w_next = 16'h9999;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_val <= '0;
      end else if (clr) begin
         r_val <= '0;
      end else begin
         r_val <= w_next;
      end
   end

   assign o_value = r_val;

endmodule

// File: rtl/collision_score.sv
// Per-frame player/obstacle/floor collision check, BCD scoring and game-state FSM.
// Optional best-score register enabled by defining HI_SCORE_EN.
module collision_score
   import flappy_pkg::*;
#(
   parameter int NUM_OBS    = 2,
   parameter int P_W        = 20,
   parameter int P_H        = 20,
   parameter int HIT_FRAMES = 60,
   parameter int FLOOR_Y    = 479
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   frame_tick,
   input  logic                   start,
   input  logic [9:0]             p_x,
   input  logic [9:0]             p_y,
   input  logic [10*NUM_OBS-1:0]  obs_x,
   input  logic [10*NUM_OBS-1:0]  obs_gap,
   output logic [1:0]             state,
   output logic                   freeze,
   output logic                   hit_pulse,
   output logic [15:0]            score_bcd,
   output logic [15:0]            hi_score_bcd
);

   localparam int TMR_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HIT_FRAMES - 1);

   game_state_t           r_state;
   logic                  r_freeze;
   logic                  r_hit_pulse;
   logic [TMR_W-1:0]      r_timer;
   logic                  r_start_q;
   logic [10*NUM_OBS-1:0] r_prev_x;

   logic                  w_rise;
   logic [10:0]           w_px;
   logic [10:0]           w_py;
   logic [NUM_OBS-1:0]    w_h_ov;
   logic [NUM_OBS-1:0]    w_v_out;
   logic [NUM_OBS-1:0]    w_pass;
   logic                  w_hit_now;
   logic [7:0]            w_pass_cnt;
   logic [1:0]            w_inc;
   logic [1:0]            w_score_inc;
   logic                  w_score_clr;
   logic [15:0]           w_score;

   assign w_rise = start & ~r_start_q;
   assign w_px   = {1'b0, p_x};
   assign w_py   = {1'b0, p_y};

   // Everything is widened to 11 bits so the right-hand sums never wrap.
   for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
      logic [10:0] w_ox;
      logic [10:0] w_og;
      logic [10:0] w_prev;
      assign w_ox       = {1'b0, obs_x[10*g +: 10]};
      assign w_og       = {1'b0, obs_gap[10*g +: 10]};
      assign w_prev     = {1'b0, r_prev_x[10*g +: 10]};
      assign w_h_ov[g]  = (w_px <= w_ox) && (w_ox <= w_px + 11'(P_W + T_W - 2));
      assign w_v_out[g] = (w_py < w_og) || (w_py + 11'(P_H - 1) >= w_og + 11'(S_Z - 1));
      assign w_pass[g]  = (w_prev >= w_px) && (w_ox < w_px);
   end

   assign w_hit_now = (|(w_h_ov & w_v_out)) || (w_py + 11'(P_H - 1) >= 11'(FLOOR_Y));

   always_comb begin
      w_pass_cnt = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         w_pass_cnt = w_pass_cnt + {7'd0, w_pass[i]};
      end
      w_inc = (w_pass_cnt > 8'd2) ? 2'd2 : w_pass_cnt[1:0];
   end

   assign w_score_inc = ((r_state == ST_PLAY) && frame_tick && !w_hit_now) ? w_inc : 2'd0;
   assign w_score_clr = (r_state == ST_IDLE) && w_rise;

   bcd_counter4 u_score (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (w_score_clr),
      .inc     (w_score_inc),
      .o_value (w_score)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_freeze    <= 1'b1;
         r_hit_pulse <= 1'b0;
         r_timer     <= '0;
         r_start_q   <= 1'b0;
         r_prev_x    <= '0;
      end else begin
         r_start_q   <= start;
         r_hit_pulse <= 1'b0;
         if (frame_tick) r_prev_x <= obs_x;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state  <= ST_PLAY;
                  r_freeze <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (frame_tick && w_hit_now) begin
                  r_state     <= ST_HIT;
                  r_freeze    <= 1'b1;
                  r_hit_pulse <= 1'b1;
                  r_timer     <= '0;
               end
            end
            ST_HIT: begin
               if (frame_tick) begin
                  if (r_timer == TMR_LAST) r_state <= ST_OVER;
                  else r_timer <= r_timer + TMR_W'(1);
               end
            end
            ST_OVER: begin
               if (w_rise) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef HI_SCORE_EN
   logic [15:0] r_hi;
   logic        w_over_entry;

   assign w_over_entry = (r_state == ST_HIT) && frame_tick && (r_timer == TMR_LAST);

   // Packed BCD orders the same as binary, so a plain compare picks the best score.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi <= '0;
      end else if (w_over_entry && (w_score > r_hi)) begin
         r_hi <= w_score;
      end
   end

   assign hi_score_bcd = r_hi;
`else
   assign hi_score_bcd = 16'h0000;
`endif

   assign state     = r_state;
   assign freeze    = r_freeze;
   assign hit_pulse = r_hit_pulse;
   assign score_bcd = w_score;

endmodule
